retire_trace_buffer: RTL

RETIRE_TRACE_BUFFER -- requirements
Module: retire_trace_buffer

---
 rtl/trace_pkg.sv | 37 +++
 rtl/trace_fifo.sv | 78 +++++++
 rtl/retire_trace_buffer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trace_pkg
//  Description : Shared types for the retire trace buffer: the stored trace
//                entry layout and the capture state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package trace_pkg;

    // Width of the PC / writeback data fields held in a trace entry. The
    // top-level XLEN parameter must match this value.
    localparam int TRACE_XLEN = 32;

    // One retired instruction as captured into the trace store.
    typedef struct packed {
        logic [TRACE_XLEN-1:0] pc;
        logic [31:0]           instr;
        logic                  we;
        logic [4:0]            rd;
        logic [TRACE_XLEN-1:0] data;
    } trace_entry_t;

    // Capture controller states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        HALT    = 2'd3
    } trace_state_t;

    // A register write that targets x0 carries no architectural information.
    function automatic logic is_x0_write(input logic we, input logic [4:0] rd);
        return we && (rd == 5'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : trace_fifo
//  Description : Power-of-two circular store for trace entries. Supports a
//                simultaneous push/pop at any fill level and, when overwrite
//                is set, evicts the oldest entry to make room on a full push.
//  Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo #(
    parameter int  DEPTH   = 16,
    parameter type ENTRY_T = logic [7:0],
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             overwrite,
    input  ENTRY_T           push_data,
    output ENTRY_T           head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    ENTRY_T           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    logic do_pop;
    logic evict;
    logic do_write;
    logic do_read;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign head  = mem[rd_ptr];

    // A full push is accepted when a slot frees this cycle or when the oldest
    // entry may be sacrificed; the eviction advances the read side as a pop.
    assign do_pop   = pop && !empty;
    assign evict    = push && full && !do_pop && overwrite;
    assign do_write = push && (!full || do_pop || overwrite);
    assign do_read  = do_pop || evict;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_write && !do_read) begin
                cnt <= cnt + CNT_W'(1);
            end else if (do_read && !do_write) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Entry storage; contents are not reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/retire_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : retire_trace_buffer
//  Description : Captures retired instructions from the writeback stage into
//                a trace FIFO, optionally starting on a PC trigger, filtering
//                x0 writes and counting events lost to a full buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module retire_trace_buffer
    import trace_pkg::*;
#(
    parameter int XLEN      = TRACE_XLEN,
    parameter int DEPTH     = 16,
    parameter int OVERWRITE = 0,
    parameter int FILTER_X0 = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_valid,
    input  logic [XLEN-1:0]          wb_pc,
    input  logic [31:0]              wb_instr,
    input  logic                     wb_we,
    input  logic [4:0]               wb_rd,
    input  logic [XLEN-1:0]          wb_data,
    input  logic                     trig_en,
    input  logic [XLEN-1:0]          trig_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [31:0]              out_instr,
    output logic                     out_we,
    output logic [4:0]               out_rd,
    output logic [XLEN-1:0]          out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              drop_cnt,
    output logic                     capturing
);

    trace_state_t state;
    trace_state_t state_next;

    trace_entry_t wr_entry;
    trace_entry_t head;

    logic x0_filtered;
    logic eligible;
    logic trig_hit;
    logic capture_now;
    logic push;
    logic pop;
    logic overflow;
    logic lost;
    logic fifo_full;
    logic fifo_empty;

    // Event qualification: the trigger-matching retire is captured itself.
    assign x0_filtered = (FILTER_X0 != 0) && is_x0_write(wb_we, wb_rd);
    assign eligible    = wb_valid && !x0_filtered;
    assign trig_hit    = (state == ARMED) && wb_valid && (wb_pc == trig_pc);
    assign capture_now = (state == CAPTURE) || trig_hit;
    assign push        = capture_now && eligible;

    // Head is visible only outside reset; gating also hides stale storage.
    assign out_valid = reset && !fifo_empty;
    assign pop       = out_valid && out_ready;

    // Events refused by a full buffer, evicted by overwrite, or arriving
    // after capture halted on overflow are all accounted as lost.
    assign overflow = push && fifo_full && !pop;
    assign lost     = overflow || (eligible && (state == HALT));

    assign wr_entry = '{pc: wb_pc, instr: wb_instr, we: wb_we, rd: wb_rd, data: wb_data};

    trace_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_T (trace_entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .overwrite (OVERWRITE != 0),
        .push_data (wr_entry),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    assign out_pc    = out_valid ? head.pc    : '0;
    assign out_instr = out_valid ? head.instr : '0;
    assign out_we    = out_valid ? head.we    : 1'b0;
    assign out_rd    = out_valid ? head.rd    : '0;
    assign out_data  = out_valid ? head.data  : '0;

    // Capture state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and capture indication; capturing also covers the trigger cycle.
    always_comb begin
        state_next = state;
        capturing  = reset && capture_now;
        case (state)
            IDLE:    state_next = trig_en ? ARMED : CAPTURE;
            ARMED:   if (trig_hit) state_next = CAPTURE;
            CAPTURE: if (overflow && (OVERWRITE == 0)) state_next = HALT;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    // Saturating lost-event counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (lost && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule
`default_nettype wire
